// File: rtl/fft_butterfly_6_if.sv
// Handshake and data bundle for the radix-2 butterfly: upper-leg sample in, twiddle product in, result pair out.
interface fft_butterfly_6_if #(
  parameter int unsigned DW = 12,
  parameter int unsigned PW = 24
);
  logic [DW-1:0] x_real;
  logic [DW-1:0] x_img;
  logic          x_valid;
  logic          x_ready;

  logic [PW-1:0] prod_real;
  logic [PW-1:0] prod_img;
  logic          prod_valid;
  logic          prod_ready;

  logic [DW-1:0] y0_real;
  logic [DW-1:0] y0_img;
  logic [DW-1:0] y1_real;
  logic [DW-1:0] y1_img;
  logic          out_valid;
  logic          out_ready;

  // Upstream/downstream side: offers samples and products, consumes results.
  modport master (
    output x_real, x_img, x_valid,
    input  x_ready,
    output prod_real, prod_img, prod_valid,
    input  prod_ready,
    input  y0_real, y0_img, y1_real, y1_img, out_valid,
    output out_ready
  );

  // Butterfly side.
  modport slave (
    input  x_real, x_img, x_valid,
    output x_ready,
    input  prod_real, prod_img, prod_valid,
    output prod_ready,
    output y0_real, y0_img, y1_real, y1_img, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/fft_butterfly_6.sv
// Radix-2 DIT butterfly: buffers upper-leg samples until the matching W*b product arrives,
// then registers y0 = (x + p) >>> 1 and y1 = (x - p) >>> 1 with the product clamped to DW bits.
module fft_butterfly_6 #(
  parameter int unsigned DW    = 12,
  parameter int unsigned PW    = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  fft_butterfly_6_if.slave         bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     sat_flag
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic signed [PW-1:0] P_MAX = PW'((1 << (DW - 1)) - 1);
  localparam logic signed [PW-1:0] P_MIN = PW'(-(1 << (DW - 1)));

  logic [DW-1:0] mem_re [DEPTH];
  logic [DW-1:0] mem_im [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [DW-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
  logic          out_valid_q;

  logic          x_ready_c;
  logic          prod_ready_c;
  logic          push_c;
  logic          fire_c;

  logic signed [PW-1:0] pr_c, pi_c;
  logic signed [DW-1:0] p_re_c, p_im_c;
  logic                 clip_c;
  logic signed [DW-1:0] x_re_c, x_im_c;
  logic signed [DW:0]   s_re_c, s_im_c, d_re_c, d_im_c;

  // Handshakes: a full FIFO refuses a push even when a pop happens in the same cycle.
  always_comb begin
    x_ready_c    = en && (fifo_count < CW'(DEPTH));
    prod_ready_c = en && (fifo_count != CW'(0)) && (!out_valid_q || bus.out_ready);
    push_c       = bus.x_valid && x_ready_c;
    fire_c       = bus.prod_valid && prod_ready_c;
  end

  assign bus.x_ready    = x_ready_c;
  assign bus.prod_ready = prod_ready_c;

  // Clamp the product to the DW-bit sample range before the add/subtract.
  always_comb begin
    pr_c   = $signed(bus.prod_real);
    pi_c   = $signed(bus.prod_img);
    p_re_c = DW'(pr_c);
    p_im_c = DW'(pi_c);
    clip_c = 1'b0;
    if (pr_c > P_MAX) begin
      p_re_c = DW'(P_MAX);
      clip_c = 1'b1;
    end else if (pr_c < P_MIN) begin
      p_re_c = DW'(P_MIN);
      clip_c = 1'b1;
    end
    if (pi_c > P_MAX) begin
      p_im_c = DW'(P_MAX);
      clip_c = 1'b1;
    end else if (pi_c < P_MIN) begin
      p_im_c = DW'(P_MIN);
      clip_c = 1'b1;
    end
  end

  // Sum and difference in DW+1 bits so the halving never overflows.
  always_comb begin
    x_re_c = $signed(mem_re[rd_ptr]);
    x_im_c = $signed(mem_im[rd_ptr]);
    s_re_c = {x_re_c[DW-1], x_re_c} + {p_re_c[DW-1], p_re_c};
    s_im_c = {x_im_c[DW-1], x_im_c} + {p_im_c[DW-1], p_im_c};
    d_re_c = {x_re_c[DW-1], x_re_c} - {p_re_c[DW-1], p_re_c};
    d_im_c = {x_im_c[DW-1], x_im_c} - {p_im_c[DW-1], p_im_c};
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_re[wr_ptr] <= bus.x_real;
      mem_im[wr_ptr] <= bus.x_img;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (fire_c) rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, fire_c})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Result registers: a fire always loads a fresh pair, otherwise a taken pair retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_re_q     <= '0;
      y0_im_q     <= '0;
      y1_re_q     <= '0;
      y1_im_q     <= '0;
      out_valid_q <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      if (fire_c) begin
        y0_re_q     <= s_re_c[DW:1];
        y0_im_q     <= s_im_c[DW:1];
        y1_re_q     <= d_re_c[DW:1];
        y1_im_q     <= d_im_c[DW:1];
        out_valid_q <= 1'b1;
        if (clip_c) sat_flag <= 1'b1;
      end else if (en && out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.y0_real   = y0_re_q;
  assign bus.y0_img    = y0_im_q;
  assign bus.y1_real   = y1_re_q;
  assign bus.y1_img    = y1_im_q;
  assign bus.out_valid = out_valid_q;

endmodule
